// File: rtl/imm_ext_pipe_if.sv
// imm_ext_pipe_if: input/output valid-ready streams of the immediate extension pipe
interface imm_ext_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (
        output in_valid, in_imm, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_imm, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: pipelined zero/sign/upper/branch immediate extender with backpressure and flush
module imm_ext_pipe #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int STAGES = 2
) (
    input logic           clk,
    input logic           reset,
    input logic           flush,
    imm_ext_pipe_if.slave bus
);
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] sv;
    logic [OUT_W-1:0]  d  [STAGES];
    logic [OUT_W-1:0]  sd [STAGES];
    logic [OUT_W-1:0]  ext;
    logic [OUT_W-1:0]  sx;
    logic              take;
    logic              full;

    // extension of the offered immediate, selected by mode
    always_comb begin
        sx  = {{(OUT_W-IN_W){bus.in_imm[IN_W-1]}}, bus.in_imm};
        ext = bus.in_mode == 2'd0 ? {{(OUT_W-IN_W){1'b0}}, bus.in_imm} :
              bus.in_mode == 2'd1 ? sx :
              bus.in_mode == 2'd2 ? {bus.in_imm, {(OUT_W-IN_W){1'b0}}} :
                                    {sx[OUT_W-3:0], 2'b00};
    end

    // a stage is ready unless it and every stage after it are full and the output is stalled
    always_comb begin
        full = 1'b1;
        for (int k = STAGES - 1; k >= 0; k--) begin
            full   = full & v[k];
            rdy[k] = bus.out_ready | !full;
        end
    end

    // source of each stage: the accepted input for stage 0, the previous stage otherwise
    always_comb begin
        sv[0] = take;
        sd[0] = ext;
        for (int k = 1; k < STAGES; k++) begin
            sv[k] = v[k-1];
            sd[k] = d[k-1];
        end
    end

    assign bus.in_ready  = rdy[0] & !flush;
    assign take          = bus.in_valid & bus.in_ready;
    assign bus.out_valid = v[STAGES-1];
    assign bus.out_data  = d[STAGES-1];

    // ready stages advance; data only moves with a valid entry so held data stays stable
    always_ff @(posedge clk) begin
        if (reset) begin
            v <= '0;
            for (int k = 0; k < STAGES; k++) d[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v[k] <= sv[k];
                    if (sv[k]) d[k] <= sd[k];
                end
            end
            if (flush) v <= '0;
        end
    end
endmodule
